// File: rtl/alu_request_sequencer.sv
// Round-robin front end sharing one 16-bit ALU between two requesters.
// Runs narrow ops in one pass, wide (32-bit) ops in two, and returns result+flags.
//
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-low reset
//   req0_*/req1_*           valid/ready command ports (funsel, wide, wf, a, b)
//   rsp_*                   shared response port (valid/ready, id, data, flags, err)
//   busy                    sequencer not idle
//   alu_a/alu_b/alu_funsel/alu_wf  drive to the ALU
//   alu_out/alu_flags       ALU result (combinational) and flag register {Z,C,N,O}
module alu_request_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_funsel,
  input  logic        req0_wide,
  input  logic        req0_wf,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_funsel,
  input  logic        req1_wide,
  input  logic        req1_wf,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_funsel,
  output logic        alu_wf,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_FLG  = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  localparam logic [4:0] F_ADD = 5'b10100;
  localparam logic [4:0] F_ADC = 5'b10101;

  logic [2:0]  state;
  logic        ptr;
  logic [4:0]  c_funsel;
  logic        c_wide;
  logic        c_wf;
  logic [31:0] c_a;
  logic [31:0] c_b;

  logic        idle;
  logic        grant0;
  logic        grant1;
  logic [4:0]  s_funsel;
  logic        s_wide;
  logic        s_wf;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_illegal;

  function automatic logic wide_ok(input logic [4:0] f);
    wide_ok = (f inside {[5'b10000:5'b10101],
                         [5'b10111:5'b11010]});
  endfunction

  assign idle = (state == S_IDLE);

  // Pointer side wins a tie; otherwise whoever is valid.
  assign grant0 = req0_valid & (~ptr | ~req1_valid);
  assign grant1 = req1_valid & (ptr | ~req0_valid);

  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;

  assign s_funsel  = grant0 ? req0_funsel : req1_funsel;
  assign s_wide    = grant0 ? req0_wide   : req1_wide;
  assign s_wf      = grant0 ? req0_wf     : req1_wf;
  assign s_a       = grant0 ? req0_a      : req1_a;
  assign s_b       = grant0 ? req0_b      : req1_b;
  assign s_illegal = s_wide & ~wide_ok(s_funsel);

  assign rsp_valid = (state == S_RSP);
  assign busy      = ~idle;

  // ALU sees operands only during a pass, so its flags never move otherwise.
  always_comb begin
    alu_a      = 16'h0;
    alu_b      = 16'h0;
    alu_funsel = 5'h0;
    alu_wf     = 1'b0;
    case (state)
      S_LO: begin
        alu_a      = c_a[15:0];
        alu_b      = c_b[15:0];
        alu_funsel = c_funsel;
        alu_wf     = c_wide | c_wf;
      end
      S_HI: begin
        alu_a      = c_a[31:16];
        alu_b      = c_b[31:16];
        alu_funsel = (c_funsel == F_ADD) ? F_ADC : c_funsel;
        alu_wf     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      c_funsel  <= 5'h0;
      c_wide    <= 1'b0;
      c_wf      <= 1'b0;
      c_a       <= 32'h0;
      c_b       <= 32'h0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_flags <= 4'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 | grant1) begin
            ptr       <= grant0;
            rsp_id    <= grant1;
            c_funsel  <= s_funsel;
            c_wide    <= s_wide;
            c_wf      <= s_wf;
            c_a       <= s_a;
            c_b       <= s_b;
            rsp_data  <= 32'h0;
            rsp_flags <= 4'h0;
            rsp_err   <= s_illegal;
            state     <= s_illegal ? S_RSP : S_LO;
          end
        end
        S_LO: begin
          rsp_data[15:0] <= alu_out;
          state          <= c_wide ? S_HI : S_FLG;
        end
        S_HI: begin
          rsp_data[31:16] <= alu_out;
          state           <= S_FLG;
        end
        S_FLG: begin
          // Wide Z must cover all 32 bits, not just the high pass.
          if (c_wide)
            rsp_flags <= {rsp_data == 32'h0, alu_flags[2:0]};
          else
            rsp_flags <= c_wf ? alu_flags : 4'h0;
          state <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_sequencer.sv
// Scoreboard bench for alu_request_sequencer with a small ALU model.
// Directed vectors; monitor pops expected responses on each handshake.
module tb_alu_request_sequencer;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [4:0]  f;
    logic        wide;
    logic        wf;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef struct {
    logic [4:0]  f;
    logic [15:0] a;
  } pass_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_funsel = '0;
  logic        req0_wide = 1'b0;
  logic        req0_wf = 1'b0;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_funsel = '0;
  logic        req1_wide = 1'b0;
  logic        req1_wf = 1'b0;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_funsel;
  logic        alu_wf;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags = 4'h0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t  exp_q[$];
  pass_t plog[$];

  alu_request_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_funsel(req0_funsel), .req0_wide(req0_wide),
    .req0_wf(req0_wf), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_funsel(req1_funsel), .req1_wide(req1_wide),
    .req1_wf(req1_wf), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_funsel(alu_funsel), .alu_wf(alu_wf),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // ALU model: ADD, ADC, AND, OR, XOR; pass-A otherwise.
  logic [16:0] sum;
  logic [15:0] out_c;
  logic        cy;
  logic        ov;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b}
        + {16'h0, (alu_funsel == 5'b10101) & alu_flags[2]};
    out_c = alu_a;
    cy = 1'b0;
    ov = 1'b0;
    case (alu_funsel)
      5'b10100, 5'b10101: begin
        out_c = sum[15:0];
        cy = sum[16];
        ov = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      5'b10111: out_c = alu_a & alu_b;
      5'b11000: out_c = alu_a | alu_b;
      5'b11001: out_c = alu_a ^ alu_b;
      default: out_c = alu_a;
    endcase
  end
  assign alu_out = out_c;
  always @(posedge Clock)
    if (alu_wf) alu_flags <= {out_c == 16'h0, cy, out_c[15], ov};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [31:0] d,
                              input logic [3:0] f, input logic e,
                              input int l);
    exp_t x;
    x.id = id; x.data = d; x.flags = f; x.err = e; x.lat = l;
    return x;
  endfunction

  function automatic cmd_t cm(input logic [4:0] f, input logic w,
                              input logic wf, input logic [31:0] a,
                              input logic [31:0] b);
    cmd_t c;
    c.f = f; c.wide = w; c.wf = wf; c.a = a; c.b = b;
    return c;
  endfunction

  // Monitor: latency, stability under backpressure, scoreboard pop.
  initial begin
    bit    seen = 0;
    bit    pend = 0;
    int    lat = 0;
    logic [37:0] prev = '0;
    exp_t  e;
    forever begin
      @(negedge Clock);
      if (alu_wf) plog.push_back('{alu_funsel, alu_a});
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
        acc_cyc = cyc + 1;
      if (pend) begin
        if (rsp_valid)
          check("hold_stable", {rsp_id, rsp_data, rsp_flags, rsp_err}, prev);
        else
          check("hold_valid", rsp_valid, 1'b1);
      end
      if (rsp_valid && !seen) begin
        seen = 1;
        lat = cyc - acc_cyc + 1;
      end
      if (rsp_valid && rsp_ready) begin
        seen = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got id %0d data %0h expected none",
                   rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_flags", rsp_flags, e.flags);
          check("rsp_err", rsp_err, e.err);
          check("latency", lat, e.lat);
        end
      end
      pend = rsp_valid && !rsp_ready;
      prev = {rsp_id, rsp_data, rsp_flags, rsp_err};
    end
  end

  task automatic drive0(input cmd_t c);
    int n = 0;
    req0_funsel = c.f; req0_wide = c.wide; req0_wf = c.wf;
    req0_a = c.a; req0_b = c.b; req0_valid = 1'b1;
    while (n < 100) begin
      @(negedge Clock);
      if (req0_ready) break;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drive0_timeout: got no ready expected ready");
    end else begin
      @(posedge Clock);
      #1;
    end
    req0_valid = 1'b0;
  endtask

  task automatic drive1(input cmd_t c);
    int n = 0;
    req1_funsel = c.f; req1_wide = c.wide; req1_wf = c.wf;
    req1_a = c.a; req1_b = c.b; req1_valid = 1'b1;
    while (n < 100) begin
      @(negedge Clock);
      if (req1_ready) break;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drive1_timeout: got no ready expected ready");
    end else begin
      @(posedge Clock);
      #1;
    end
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 60) begin
      @(negedge Clock);
      if (exp_q.size() == 0 && !rsp_valid) break;
      n++;
    end
    if (n >= 60) begin
      tests++; fails++;
      $display("FAIL wait_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_flags", rsp_flags, 4'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_alu", {alu_a, alu_b, alu_funsel, alu_wf}, 38'h0);
    @(posedge Clock);
    #1 Reset = 1'b1;

    // Narrow ADD with signed overflow.
    exp_q.push_back(mk(0, 32'h0000_8000, 4'b0011, 0, 3));
    drive0(cm(5'b10100, 0, 1, 32'h0000_7FFF, 32'h0000_0001));
    wait_idle();

    // Wide ADD: carry propagates via ADC on the high pass.
    plog.delete();
    exp_q.push_back(mk(1, 32'h0001_0000, 4'b0000, 0, 4));
    drive1(cm(5'b10100, 1, 0, 32'h0000_FFFF, 32'h0000_0001));
    wait_idle();
    check("wide_passes", plog.size(), 2);
    if (plog.size() == 2) begin
      check("lo_funsel", plog[0].f, 5'b10100);
      check("lo_a", plog[0].a, 16'hFFFF);
      check("hi_funsel", plog[1].f, 5'b10101);
      check("hi_a", plog[1].a, 16'h0000);
    end

    // Narrow XOR without flag write: high halves ignored, flags 0.
    exp_q.push_back(mk(0, 32'h0000_0FFF, 4'b0000, 0, 3));
    drive0(cm(5'b11001, 0, 0, 32'h1234_00F0, 32'hFFFF_0F0F));
    wait_idle();

    // Narrow AND to zero with flag write.
    exp_q.push_back(mk(1, 32'h0000_0000, 4'b1000, 0, 3));
    drive1(cm(5'b10111, 0, 1, 32'h0000_00F0, 32'h0000_0F0F));
    wait_idle();

    // Wide XOR: low half zero, result not zero, N from high.
    exp_q.push_back(mk(0, 32'h8000_0000, 4'b0010, 0, 4));
    drive0(cm(5'b11001, 1, 0, 32'h8000_0001, 32'h0000_0001));
    wait_idle();

    // Wide OR: high pass zero but 32-bit result nonzero -> Z=0.
    exp_q.push_back(mk(0, 32'h0000_0001, 4'b0000, 0, 4));
    drive0(cm(5'b11000, 1, 1, 32'h0000_0001, 32'h0000_0000));
    wait_idle();

    // Wide ADD wrapping to zero with carry out.
    exp_q.push_back(mk(1, 32'h0000_0000, 4'b1100, 0, 4));
    drive1(cm(5'b10100, 1, 1, 32'hFFFF_FFFF, 32'h0000_0001));
    wait_idle();

    // Illegal wide code under backpressure.
    plog.delete();
    rsp_ready = 1'b0;
    exp_q.push_back(mk(0, 32'h0, 4'h0, 1, 1));
    drive0(cm(5'b11011, 1, 1, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (5) @(posedge Clock);
    #1 rsp_ready = 1'b1;
    wait_idle();
    check("err_no_pass", plog.size(), 0);

    // 10110 is also not a legal wide code.
    exp_q.push_back(mk(1, 32'h0, 4'h0, 1, 1));
    drive1(cm(5'b10110, 1, 0, 32'h1, 32'h1));
    wait_idle();

    // Reset during the high pass aborts with no response.
    drive0(cm(5'b10100, 1, 0, 32'h0000_FFFF, 32'h0000_0001));
    @(posedge Clock);
    @(negedge Clock);
    check("in_hi_funsel", alu_funsel, 5'b10101);
    check("in_hi_wf", alu_wf, 1'b1);
    Reset = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_wf", alu_wf, 1'b0);
    @(posedge Clock);
    #1;

    // Both requesters held valid: pointer reset to 0, grants alternate.
    exp_q.push_back(mk(0, 32'h0000_0002, 4'b0000, 0, 3));
    exp_q.push_back(mk(1, 32'h0000_0FF0, 4'b0000, 0, 3));
    exp_q.push_back(mk(0, 32'h0000_0000, 4'b1100, 0, 3));
    exp_q.push_back(mk(1, 32'h0000_FFFE, 4'b0010, 0, 3));
    exp_q.push_back(mk(0, 32'h0000_0000, 4'b1101, 0, 3));
    exp_q.push_back(mk(1, 32'h0000_8000, 4'b0010, 0, 3));
    fork
      begin
        drive0(cm(5'b10100, 0, 1, 32'h0001, 32'h0001));
        drive0(cm(5'b10100, 0, 1, 32'hFFFF, 32'h0001));
        drive0(cm(5'b10100, 0, 1, 32'h8000, 32'h8000));
      end
      begin
        drive1(cm(5'b11000, 0, 1, 32'h00F0, 32'h0F00));
        drive1(cm(5'b11001, 0, 1, 32'hFFFF, 32'h0001));
        drive1(cm(5'b10111, 0, 1, 32'h8000, 32'hFFFF));
      end
    join
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
